des_dpram: RTL and testbench
============================

# des_dpram

Parametrised true dual-port word memory for the DES datapath, the successor to the fixed 64x64 two-port store used for key and block buffering. It adds configurable width, depth and read latency, a hardware clear sequence after reset or on request, defined same-address collision behaviour and per-port valid strobes. It sits between the key schedule / round engine and the testbench-facing load/unload logic.

## Interface
- DATA_W, 64, word width in bits.
- ADDR_W, 6, address width; depth is 2**ADDR_W words.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2; anything else is a compile-time error.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when 0, no request is accepted and outputs are forced to 0.
- clr  in  1  single-cycle pulse; starts a clear sweep when the block is READY.
- req0 / req1  in  1  request strobe, port 0 / port 1.
- wr0 / wr1  in  1  access type: 0 = write, 1 = read.
- add0 / add1  in  ADDR_W  word address.
- data0_in / data1_in  in  DATA_W  write data.
- data0_out / data1_out  out  DATA_W  read data; valid only while the matching valid strobe is high.
- valid0 / valid1  out  1  one-cycle strobe marking returned read data.
- busy  out  1  high while a clear sweep runs; requests are ignored.
- collision  out  1  one-cycle pulse when the two ports accept requests to the same address in one cycle and at least one of them is a write.
- perr0 / perr1  out  1  parity error, qualified by the matching valid strobe. Tied to 0 unless parity is compiled in.

## Operation
- The FSM has two states: CLEAR and READY. Reset puts it in CLEAR with the sweep counter at 0.
- CLEAR:
  - Writes 0 (and matching parity) to address = counter, one word per cycle.
  - After writing address 2**ADDR_W-1, the FSM moves to READY. The sweep takes exactly 2**ADDR_W cycles.
  - clr and all requests are ignored during CLEAR.
- READY:
  - clr=1 returns the FSM to CLEAR with the counter at 0. Any request in that same cycle is ignored.
- A request on port p is accepted when req_p=1, en=1, state=READY and clr=0.
  - Accepted write: the memory word updates at that clock edge.
  - Accepted read: data_p_out and valid_p appear READ_LAT cycles later.
- Same-address collisions in one cycle:
  - Write/write: port 0's data is stored; collision pulses.
  - Write/read: the read returns the old contents (read-first); collision pulses.
  - Read/read: both ports return the same data; no collision.
- en=0:
  - The output registers load 0 and valid0/valid1 are 0.
  - Reads already in the pipeline are discarded, not delayed.
  - Memory contents are kept.
- Reset mid-operation:
  - Clears the read pipeline and all outputs.
  - Restarts the clear sweep from address 0. Memory contents before the sweep are don't-care.

## Timing
- Reset values: data0_out/data1_out 0, valid0/valid1 0, collision 0, perr0/perr1 0, busy 1.
- busy is high for exactly 2**ADDR_W cycles after reset deasserts and after each accepted clr. It falls in the cycle the FSM enters READY.
- Read latency is exactly READ_LAT cycles from the accepting edge.
  - READ_LAT=1: registered output.
  - READ_LAT=2: an extra output register stage.
- Each port accepts one request per cycle, back-to-back, with no bubbles.
- data_p_out holds its last value between valid strobes, except under en=0, where it is 0.
- collision is registered: it appears one cycle after the colliding request edge.

## Configuration
- DES_DPRAM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed on write.
  - On read, the parity is recomputed; perr_p=1 together with valid_p on a mismatch.
  - Clear writes a parity bit consistent with all-zero data.
- DES_DPRAM_PARITY_EN undefined:
  - Storage is DATA_W bits per word.
  - perr0/perr1 are constant 0.

## Structure
- Package des_mem_pkg: the FSM state enum (CLEAR, READY), the legal READ_LAT values, and the parity function.
- Sub-module des_dpram_rdpipe: the per-port read pipeline (READ_LAT stages of data/valid/perr with en-flush). It is instantiated twice.
- Top level: the storage array, the clear FSM/counter and collision detection.

## Test plan
All scenarios use DATA_W=64, ADDR_W=6, READ_LAT=1 unless noted.
- Reset, then read every address after busy falls -> busy high exactly 64 cycles; every read returns 0 with valid for 1 cycle.
- Port0 writes 0x0123456789ABCDEF to 5, then port1 reads 5 -> data1_out=0x0123456789ABCDEF one cycle after the read; valid1 for 1 cycle.
- Same cycle: port0 writes 0xAAAA to 9, port1 writes 0x5555 to 9; then read 9 -> returns 0xAAAA; collision pulses once.
- Address 3 holds 0x11. Port0 writes 0x22 to 3 while port1 reads 3 -> port1 gets 0x11, a later read gets 0x22, collision pulses.
- Port0 reads address 4 with en=1, then en=0 on the next cycle -> valid0=0 and data0_out=0; with READ_LAT=2, the in-flight read is discarded.
- clr pulse in READY, or rst low for 1 cycle mid-stream -> busy for 64 cycles; all words read back 0 afterwards; requests during busy have no effect.

Source files
------------

// File: rtl/des_mem_pkg.sv
// Shared types and helpers for the DES dual-port word store.
// No logic; no latency; no backpressure.
// Holds the clear-FSM states, the legal read latencies and the parity helper.
package des_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;
  localparam int PAR_MAX_W    = 256;

  function automatic bit read_lat_legal(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/des_dpram_if.sv
// Request/response bundle for both ports of des_dpram.
// No logic; no latency; no backpressure.
// master drives requests, slave is the memory.
interface des_dpram_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
);
  logic              en;
  logic              clr;
  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] add0;
  logic [ADDR_W-1:0] add1;
  logic [DATA_W-1:0] data0_in;
  logic [DATA_W-1:0] data1_in;
  logic [DATA_W-1:0] data0_out;
  logic [DATA_W-1:0] data1_out;
  logic              valid0;
  logic              valid1;
  logic              busy;
  logic              collision;
  logic              perr0;
  logic              perr1;

  modport master (
    output en, clr, req0, req1, wr0, wr1, add0, add1, data0_in, data1_in,
    input  data0_out, data1_out, valid0, valid1, busy, collision, perr0, perr1
  );

  modport slave (
    input  en, clr, req0, req1, wr0, wr1, add0, add1, data0_in, data1_in,
    output data0_out, data1_out, valid0, valid1, busy, collision, perr0, perr1
  );
endinterface

// File: rtl/des_dpram_rdpipe.sv
// Per-port read return pipeline: data, valid and parity-error stages.
// Latency READ_LAT cycles from the accepting edge.
// No backpressure; en=0 flushes every stage to zero.
module des_dpram_rdpipe
  import des_mem_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rd_vld,
  input  logic [DATA_W-1:0] rd_dat,
  input  logic              rd_perr,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_vld,
  output logic              out_perr
);

  logic [DATA_W-1:0]   dat_q   [READ_LAT];
  logic [DATA_W-1:0]   dat_src [READ_LAT];
  logic [READ_LAT-1:0] vld_q;
  logic [READ_LAT-1:0] perr_q;
  logic [READ_LAT-1:0] vld_src;
  logic [READ_LAT-1:0] perr_src;

  always_comb begin
    dat_src[0]  = rd_dat;
    vld_src[0]  = rd_vld;
    perr_src[0] = rd_perr;
    for (int i = 1; i < READ_LAT; i++) begin
      dat_src[i]  = dat_q[i-1];
      vld_src[i]  = vld_q[i-1];
      perr_src[i] = perr_q[i-1];
    end
  end

  // Data only moves with a valid so the output holds between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
      vld_q  <= '0;
      perr_q <= '0;
    end else if (!en) begin
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
      vld_q  <= '0;
      perr_q <= '0;
    end else begin
      vld_q  <= vld_src;
      perr_q <= vld_src & perr_src;
      for (int i = 0; i < READ_LAT; i++) begin
        if (vld_src[i]) dat_q[i] <= dat_src[i];
      end
    end
  end

  assign out_dat  = dat_q[READ_LAT-1];
  assign out_vld  = vld_q[READ_LAT-1];
  assign out_perr = perr_q[READ_LAT-1];

endmodule

// File: rtl/des_dpram.sv
// True dual-port word store with clear sweep; optional parity via DES_DPRAM_PARITY_EN.
// Writes land at the accepting edge; reads return READ_LAT cycles later.
// No backpressure; requests are dropped while busy, during clr or with en=0.
module des_dpram
  import des_mem_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 6,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  des_dpram_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef DES_DPRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
    $error("des_dpram: READ_LAT must be 1 or 2");
  end

  logic [MEM_W-1:0]  mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              busy_q;
  logic              coll_q;
  logic              ready;
  logic              acc0, acc1, rd0, rd1, rpe0, rpe1;
  logic [MEM_W-1:0]  wdat0, wdat1, rdat0, rdat1;
  logic [DATA_W-1:0] out_dat0, out_dat1;
  logic              out_vld0, out_vld1, out_perr0, out_perr1;

  assign ready = (state == READY);
  assign acc0  = bus.req0 & bus.en & ready & ~bus.clr;
  assign acc1  = bus.req1 & bus.en & ready & ~bus.clr;
  assign rd0   = acc0 & bus.wr0;
  assign rd1   = acc1 & bus.wr1;
  assign rdat0 = mem[bus.add0];
  assign rdat1 = mem[bus.add1];

`ifdef DES_DPRAM_PARITY_EN
  assign wdat0 = {even_par(PAR_MAX_W'(bus.data0_in)), bus.data0_in};
  assign wdat1 = {even_par(PAR_MAX_W'(bus.data1_in)), bus.data1_in};
  assign rpe0  = even_par(PAR_MAX_W'(rdat0[DATA_W-1:0])) ^ rdat0[DATA_W];
  assign rpe1  = even_par(PAR_MAX_W'(rdat1[DATA_W-1:0])) ^ rdat1[DATA_W];
`else
  assign wdat0 = bus.data0_in;
  assign wdat1 = bus.data1_in;
  assign rpe0  = 1'b0;
  assign rpe1  = 1'b0;
`endif

  // All-zero word is its own even-parity encoding. Port 0 is written last so
  // it wins a same-address write/write; reads sample before the update.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[cnt] <= '0;
    end else begin
      if (acc1 && !bus.wr1) mem[bus.add1] <= wdat1;
      if (acc0 && !bus.wr0) mem[bus.add0] <= wdat0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CLEAR;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (&cnt) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        READY: begin
          if (bus.clr) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) coll_q <= 1'b0;
    else      coll_q <= acc0 & acc1 & (bus.add0 == bus.add1) & ~(bus.wr0 & bus.wr1);
  end

  des_dpram_rdpipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_rdpipe0 (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .rd_vld   (rd0),
    .rd_dat   (rdat0[DATA_W-1:0]),
    .rd_perr  (rpe0),
    .out_dat  (out_dat0),
    .out_vld  (out_vld0),
    .out_perr (out_perr0)
  );

  des_dpram_rdpipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_rdpipe1 (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .rd_vld   (rd1),
    .rd_dat   (rdat1[DATA_W-1:0]),
    .rd_perr  (rpe1),
    .out_dat  (out_dat1),
    .out_vld  (out_vld1),
    .out_perr (out_perr1)
  );

  assign bus.data0_out = out_dat0;
  assign bus.data1_out = out_dat1;
  assign bus.valid0    = out_vld0;
  assign bus.valid1    = out_vld1;
  assign bus.perr0     = out_perr0;
  assign bus.perr1     = out_perr1;
  assign bus.busy      = busy_q;
  assign bus.collision = coll_q;

endmodule

// File: tb/tb_des_dpram.sv
// Scoreboard bench for des_dpram (DATA_W=64, ADDR_W=6, READ_LAT=1).
// Expected read data is queued at issue time; a monitor pops on each valid strobe.
module tb_des_dpram;

  localparam int DW = 64;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_dpram_if #(.DATA_W(DW), .ADDR_W(AW)) b ();

  des_dpram #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // Monitor: every valid strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (b.valid0 === 1'b1) begin
      if (exp0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd0_unexpected: actual valid0 with %h required no read", b.data0_out);
      end else begin
        chk("rd0_data", b.data0_out, exp0.pop_front());
        chk("rd0_perr", 64'(b.perr0), 64'd0);
      end
    end
    if (b.valid1 === 1'b1) begin
      if (exp1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd1_unexpected: actual valid1 with %h required no read", b.data1_out);
      end else begin
        chk("rd1_data", b.data1_out, exp1.pop_front());
        chk("rd1_perr", 64'(b.perr1), 64'd0);
      end
    end
  end

  // One request cycle on both ports (rdN=1 means read), then requests drop.
  task automatic op(input logic q0, input logic rd0, input logic [5:0] a0, input logic [63:0] d0,
                    input logic q1, input logic rd1, input logic [5:0] a1, input logic [63:0] d1);
    b.req0 = q0; b.wr0 = rd0; b.add0 = a0; b.data0_in = d0;
    b.req1 = q1; b.wr1 = rd1; b.add1 = a1; b.data1_in = d1;
    @(negedge clk);
    b.req0 = 1'b0;
    b.req1 = 1'b0;
  endtask

  // Counts busy cycles; in the last expected busy cycle it tries a write,
  // a read and a clr, none of which may take effect.
  task automatic busy_run(input string nm);
    int n = 0;
    while (b.busy === 1'b1 && n < 200) begin
      n++;
      if (n == 64) begin
        b.req0 = 1'b1; b.wr0 = 1'b0; b.add0 = 6'd5; b.data0_in = 64'h55;
        b.req1 = 1'b1; b.wr1 = 1'b1; b.add1 = 6'd5;
        b.clr  = 1'b1;
      end else begin
        b.req0 = 1'b0; b.req1 = 1'b0; b.clr = 1'b0;
      end
      @(negedge clk);
    end
    b.req0 = 1'b0; b.req1 = 1'b0; b.clr = 1'b0;
    chk(nm, 64'(n), 64'd64);
  endtask

  // Back-to-back reads of every address on both ports; all must be zero.
  task automatic rd_all_zero();
    for (int i = 0; i < 64; i++) begin
      b.req0 = 1'b1; b.wr0 = 1'b1; b.add0 = 6'(i);
      b.req1 = 1'b1; b.wr1 = 1'b1; b.add1 = 6'(63 - i);
      exp0.push_back(64'd0);
      exp1.push_back(64'd0);
      @(negedge clk);
    end
    b.req0 = 1'b0;
    b.req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual time limit reached required completion");
    $fatal(1, "tb_des_dpram timeout");
  end

  initial begin
    rst = 1'b0;
    b.en = 1'b1; b.clr = 1'b0;
    b.req0 = 1'b0; b.req1 = 1'b0; b.wr0 = 1'b0; b.wr1 = 1'b0;
    b.add0 = '0; b.add1 = '0; b.data0_in = '0; b.data1_in = '0;
    repeat (2) @(negedge clk);

    chk("rst_data0", b.data0_out, 64'd0);
    chk("rst_data1", b.data1_out, 64'd0);
    chk("rst_valid0", 64'(b.valid0), 64'd0);
    chk("rst_valid1", 64'(b.valid1), 64'd0);
    chk("rst_coll", 64'(b.collision), 64'd0);
    chk("rst_perr0", 64'(b.perr0), 64'd0);
    chk("rst_perr1", 64'(b.perr1), 64'd0);
    chk("rst_busy", 64'(b.busy), 64'd1);

    rst = 1'b1;
    busy_run("busy_after_reset");
    rd_all_zero();

    // Write on port 0, read back on port 1.
    op(1, 0, 6'd5, 64'h0123456789ABCDEF, 0, 0, 6'd0, 64'd0);
    exp1.push_back(64'h0123456789ABCDEF);
    op(0, 0, 6'd0, 64'd0, 1, 1, 6'd5, 64'd0);
    chk("coll_none_diff", 64'(b.collision), 64'd0);

    // Write/write to one address: port 0 wins, collision one cycle later.
    op(1, 0, 6'd9, 64'hAAAA, 1, 0, 6'd9, 64'h5555);
    chk("coll_ww", 64'(b.collision), 64'd1);
    exp0.push_back(64'hAAAA);
    exp1.push_back(64'hAAAA);
    op(1, 1, 6'd9, 64'd0, 1, 1, 6'd9, 64'd0);
    chk("coll_rr_none", 64'(b.collision), 64'd0);

    // Write/read to one address: read returns old contents.
    op(1, 0, 6'd3, 64'h11, 0, 0, 6'd0, 64'd0);
    exp1.push_back(64'h11);
    op(1, 0, 6'd3, 64'h22, 1, 1, 6'd3, 64'd0);
    chk("coll_wr", 64'(b.collision), 64'd1);
    exp1.push_back(64'h22);
    op(0, 0, 6'd0, 64'd0, 1, 1, 6'd3, 64'd0);
    chk("coll_pulse_end", 64'(b.collision), 64'd0);

    // Output hold, then en=0 flush and ignored requests.
    op(1, 0, 6'd4, 64'hDEADBEEF, 0, 0, 6'd0, 64'd0);
    exp0.push_back(64'hDEADBEEF);
    op(1, 1, 6'd4, 64'd0, 0, 0, 6'd0, 64'd0);
    @(negedge clk);
    chk("hold_data0", b.data0_out, 64'hDEADBEEF);
    chk("hold_valid0", 64'(b.valid0), 64'd0);
    exp0.push_back(64'hDEADBEEF);
    op(1, 1, 6'd4, 64'd0, 0, 0, 6'd0, 64'd0);
    b.en = 1'b0; b.req0 = 1'b1; b.wr0 = 1'b1; b.add0 = 6'd4;
    @(negedge clk);
    chk("en0_valid0", 64'(b.valid0), 64'd0);
    chk("en0_data0", b.data0_out, 64'd0);
    b.wr0 = 1'b0; b.data0_in = 64'h77;
    @(negedge clk);
    chk("en0_data0_2", b.data0_out, 64'd0);
    b.req0 = 1'b0; b.en = 1'b1;
    @(negedge clk);
    chk("en1_hold_zero", b.data0_out, 64'd0);
    exp0.push_back(64'hDEADBEEF);
    op(1, 1, 6'd4, 64'd0, 0, 0, 6'd0, 64'd0);

    // clr pulse with a same-cycle write that must be dropped.
    b.clr = 1'b1; b.req0 = 1'b1; b.wr0 = 1'b0; b.add0 = 6'd6; b.data0_in = 64'h99;
    @(negedge clk);
    b.clr = 1'b0; b.req0 = 1'b0;
    busy_run("busy_after_clr");
    rd_all_zero();

    // Reset for one cycle mid-stream.
    op(1, 0, 6'd10, 64'h1234, 0, 0, 6'd0, 64'd0);
    exp0.push_back(64'h1234);
    op(1, 1, 6'd10, 64'd0, 0, 0, 6'd0, 64'd0);
    @(negedge clk);
    chk("hold_before_rst", b.data0_out, 64'h1234);
    rst = 1'b0; b.req0 = 1'b1; b.wr0 = 1'b1; b.add0 = 6'd10;
    @(negedge clk);
    chk("midrst_data0", b.data0_out, 64'd0);
    chk("midrst_valid0", 64'(b.valid0), 64'd0);
    chk("midrst_busy", 64'(b.busy), 64'd1);
    rst = 1'b1; b.req0 = 1'b0;
    busy_run("busy_after_midrst");
    rd_all_zero();

    repeat (3) @(negedge clk);
    chk("q0_drained", 64'(exp0.size()), 64'd0);
    chk("q1_drained", 64'(exp1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
